regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the integer and floating-point register sets of the core.
- Provides NREAD combinational read ports and two synchronous write ports. Port 0 is the main writeback; port 1 is the late writeback from multi-cycle FP/MUL-DIV units.
- Includes an optional x0-hardwired zero, optional write-to-read bypass, and a per-register busy scoreboard with an occupancy counter. Issue logic uses these for stall decisions.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers. Must be a power of two, at least 2.
- AW, $clog2(NREGS), address width (derived).
- NREAD, 3, number of read ports (1..4). Sized for FMA rs1/rs2/rs3.
- ZERO_REG, 1, 1 hardwires register 0 to zero (integer file). 0 makes register 0 a normal register (FP file).
- BYPASS, 1, 1 lets a read return same-cycle write data. 0 returns the pre-write value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NREAD*AW  read addresses; port i is at [i*AW +: AW].
- rd_data  out  NREAD*XLEN  read data; port i is at [i*XLEN +: XLEN].
- rd_busy  out  NREAD  busy flag of each read port's address.
- we0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (late writeback).
- waddr1  in  AW  write address, port 1.
- wdata1  in  XLEN  write data, port 1.
- busy_set  in  1  marks register busy_addr as pending (issue of a multi-cycle op).
- busy_addr  in  AW  register to mark busy.
- wr_conflict  out  1  registered pulse: the previous cycle had we0 & we1 to the same effective address.
- busy_count  out  AW+1  registered number of busy registers.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers clear to 0; all busy bits clear; busy_count = 0; wr_conflict = 0.
  - Reads during or after reset return 0.
  - Reset asserted mid-operation discards pending busy state and any in-flight write.
- Writes:
  - Take effect on the rising edge; the new value is visible to non-bypassed reads the next cycle.
  - If we0 & we1 target the same address in the same cycle, port 1 data is stored and wr_conflict = 1 for exactly one cycle after that edge.
- Zero register (ZERO_REG=1):
  - Writes to address 0 on either port are dropped.
  - busy_set to address 0 is ignored; address 0 always reads 0 with rd_busy = 0.
  - A write to address 0 never raises wr_conflict.
  - With ZERO_REG=0, register 0 behaves like every other register.
- Reads:
  - Purely combinational, zero latency.
  - BYPASS=1: if rd_addr matches an enabled effective write this cycle, return that write data (port 1 over port 0). Otherwise return the stored value.
  - BYPASS=0: always return the stored value.
- Scoreboard:
  - busy_set sets busy[busy_addr] at the edge.
  - A we1 write clears busy[waddr1] at the edge. A we0 write does not touch busy bits.
  - busy_set and we1 clear on the same address in the same cycle: set wins, bit stays 1 (new issue supersedes old result).
  - busy_set to an already-busy register leaves the bit at 1; busy_count is unchanged.
  - busy_count tracks the population of busy bits exactly: +1, -1, or 0 net per cycle. Never exceeds NREGS (or NREGS-1 when ZERO_REG=1).
- rd_busy[i]:
  - = busy[rd_addr_i] from stored state.
  - With BYPASS=1, it reads 0 if a we1 to that address occurs this cycle without a simultaneous busy_set to the same address.
- No X propagation: all outputs are driven from reset onward. Addresses are always in range, given the power-of-two depth.

Test Plan:
- Reset then read: pulse rst_n low, read all addresses → rd_data all 0, busy_count 0, rd_busy all 0.
- Write/read with bypass: we0 addr 5 data 0xDEADBEEF, rd_addr0 = 5 in the same cycle → BYPASS=1 returns 0xDEADBEEF that cycle; BYPASS=0 returns 0 that cycle and 0xDEADBEEF the next.
- Zero register:
  - ZERO_REG=1: we0 addr 0 data 0x1234 → reads 0; busy_set addr 0 → busy_count stays 0.
  - ZERO_REG=0: same write → reads 0x1234.
- Write conflict: we0 and we1 both to addr 7, data 0x11 / 0x22 → addr 7 reads 0x22; wr_conflict high for exactly one cycle.
- Scoreboard sequence:
  - busy_set 3, then busy_set 9 → busy_count 1 then 2; rd_busy high for addr 3.
  - we1 addr 3 → busy_count 1, rd_busy for 3 low.
  - Same-cycle busy_set 9 + we1 addr 9 → bit 9 stays set, busy_count stays 1.
- Async reset mid-operation: with busy_count 2 and registers written, assert rst_n between clock edges → outputs clear immediately; busy_count 0 and reads 0 without waiting for clk.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : regfile_mp
// Brief   : Multi-port register file with two write ports, optional zero
//           register, optional write-to-read bypass and a busy scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NREAD    = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we0,
  input  logic [AW-1:0]         waddr0,
  input  logic [XLEN-1:0]       wdata0,
  input  logic                  we1,
  input  logic [AW-1:0]         waddr1,
  input  logic [XLEN-1:0]       wdata1,
  input  logic                  busy_set,
  input  logic [AW-1:0]         busy_addr,
  output logic                  wr_conflict,
  output logic [AW:0]           busy_count
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_count;
  logic             r_wr_conflict;

  logic w_we0_eff;
  logic w_we1_eff;
  logic w_bset_eff;
  logic w_inc;
  logic w_dec;

  // With the zero register enabled, anything aimed at address 0 is dropped here.
  always_comb begin
    w_we0_eff  = we0      && !((ZERO_REG != 0) && (waddr0    == '0));
    w_we1_eff  = we1      && !((ZERO_REG != 0) && (waddr1    == '0));
    w_bset_eff = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));
    w_inc      = w_bset_eff && !r_busy[busy_addr];
    w_dec      = w_we1_eff && r_busy[waddr1] &&
                 !(w_bset_eff && (busy_addr == waddr1));
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      if (w_we0_eff) r_regs[waddr0] <= wdata0;
      if (w_we1_eff) r_regs[waddr1] <= wdata1;
    end
  end

  // A new issue supersedes a late result on the same register: set after clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy        <= '0;
      r_busy_count  <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      if (w_we1_eff)  r_busy[waddr1]    <= 1'b0;
      if (w_bset_eff) r_busy[busy_addr] <= 1'b1;
      r_busy_count  <= r_busy_count + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
      r_wr_conflict <= w_we0_eff && w_we1_eff && (waddr0 == waddr1);
    end
  end

  assign wr_conflict = r_wr_conflict;
  assign busy_count  = r_busy_count;

  generate
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] w_a;
      logic          w_hit0;
      logic          w_hit1;

      // Bypass is suppressed while reset is held so reads stay at zero.
      always_comb begin
        w_a    = rd_addr[i*AW +: AW];
        w_hit0 = (BYPASS != 0) && rst_n && w_we0_eff && (waddr0 == w_a);
        w_hit1 = (BYPASS != 0) && rst_n && w_we1_eff && (waddr1 == w_a);
        if (w_hit1) begin
          rd_data[i*XLEN +: XLEN] = wdata1;
        end else if (w_hit0) begin
          rd_data[i*XLEN +: XLEN] = wdata0;
        end else begin
          rd_data[i*XLEN +: XLEN] = r_regs[w_a];
        end
        rd_busy[i] = r_busy[w_a] &&
                     !(w_hit1 && !(w_bset_eff && (busy_addr == w_a)));
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_mp
// Brief   : Scoreboard bench for regfile_mp; checks a zero-reg/bypass instance
//           and a plain/no-bypass instance against an array model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NREAD = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREAD*AW-1:0]   rd_addr;
  logic                  we0, we1, busy_set;
  logic [AW-1:0]         waddr0, waddr1, busy_addr;
  logic [XLEN-1:0]       wdata0, wdata1;
  logic [NREAD*XLEN-1:0] rd_data_a, rd_data_b;
  logic [NREAD-1:0]      rd_busy_a, rd_busy_b;
  logic                  wr_conflict_a, wr_conflict_b;
  logic [AW:0]           busy_count_a, busy_count_b;

  always #5 clk = ~clk;

  regfile_mp u_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy_set(busy_set), .busy_addr(busy_addr), .wr_conflict(wr_conflict_a),
    .busy_count(busy_count_a)
  );

  regfile_mp #(.ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy_set(busy_set), .busy_addr(busy_addr), .wr_conflict(wr_conflict_b),
    .busy_count(busy_count_b)
  );

  typedef struct packed {
    logic [NREAD*XLEN-1:0] da, db;
    logic [NREAD-1:0]      ba, bb;
    logic [AW:0]           ca, cb;
    logic                  fa, fb;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model index 0 mirrors u_a (zero reg + bypass), index 1 mirrors u_b.
  logic [XLEN-1:0] m_mem  [2][NREGS];
  logic            m_busy [2][NREGS];
  logic            m_conf [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NREGS; r++) begin
        m_mem[k][r]  = '0;
        m_busy[k][r] = 1'b0;
      end
      m_conf[k] = 1'b0;
    end
  endtask

  function automatic logic dropped(int k, logic [AW-1:0] a);
    return (k == 0) && (a == '0);
  endfunction

  // Applies the inputs that were present at the clock edge just passed.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic e0, e1, bs;
        e0 = we0 && !dropped(k, waddr0);
        e1 = we1 && !dropped(k, waddr1);
        bs = busy_set && !dropped(k, busy_addr);
        m_conf[k] = e0 && e1 && (waddr0 == waddr1);
        if (e0) m_mem[k][waddr0] = wdata0;
        if (e1) m_mem[k][waddr1] = wdata1;
        if (e1) m_busy[k][waddr1] = 1'b0;
        if (bs) m_busy[k][busy_addr] = 1'b1;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      logic [NREAD*XLEN-1:0] d;
      logic [NREAD-1:0]      b;
      int                    cnt;
      logic e0, e1, bs;
      e0 = rst_n && we0 && !dropped(k, waddr0);
      e1 = rst_n && we1 && !dropped(k, waddr1);
      bs = busy_set && !dropped(k, busy_addr);
      for (int i = 0; i < NREAD; i++) begin
        logic [AW-1:0] a;
        a = rd_addr[i*AW +: AW];
        if (k == 0 && e1 && waddr1 == a)      d[i*XLEN +: XLEN] = wdata1;
        else if (k == 0 && e0 && waddr0 == a) d[i*XLEN +: XLEN] = wdata0;
        else                                  d[i*XLEN +: XLEN] = rst_n ? m_mem[k][a] : '0;
        b[i] = rst_n && m_busy[k][a];
        if (k == 0 && e1 && waddr1 == a && !(bs && busy_addr == a)) b[i] = 1'b0;
      end
      cnt = 0;
      for (int r = 0; r < NREGS; r++) cnt += (rst_n && m_busy[k][r]) ? 1 : 0;
      if (k == 0) begin
        e.da = d; e.ba = b; e.ca = cnt[AW:0]; e.fa = rst_n && m_conf[0];
      end else begin
        e.db = d; e.bb = b; e.cb = cnt[AW:0]; e.fb = rst_n && m_conf[1];
      end
    end
    q.push_back(e);
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; busy_set = 1'b0;
    waddr0 = '0; waddr1 = '0; busy_addr = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    idle();
  endtask

  task automatic set_rd(logic [AW-1:0] a0, logic [AW-1:0] a1, logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic chk(string name, logic [NREAD*XLEN-1:0] act, logic [NREAD*XLEN-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_data_a",     rd_data_a,     e.da);
      chk("rd_data_b",     rd_data_b,     e.db);
      chk("rd_busy_a",     {93'd0, rd_busy_a},    {93'd0, e.ba});
      chk("rd_busy_b",     {93'd0, rd_busy_b},    {93'd0, e.bb});
      chk("busy_count_a",  {90'd0, busy_count_a}, {90'd0, e.ca});
      chk("busy_count_b",  {90'd0, busy_count_b}, {90'd0, e.cb});
      chk("wr_conflict_a", {95'd0, wr_conflict_a}, {95'd0, e.fa});
      chk("wr_conflict_b", {95'd0, wr_conflict_b}, {95'd0, e.fb});
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    set_rd(5'd0, 5'd1, 5'd2);
    model_reset();
    tick(); push_exp();
    tick(); rst_n = 1'b1; push_exp();
    for (int k = 0; k < 11; k++) begin
      tick();
      set_rd(5'((3*k) % NREGS), 5'((3*k+1) % NREGS), 5'((3*k+2) % NREGS));
      push_exp();
    end

    // Same-cycle write/read: bypass instance sees new data now, the other later.
    tick(); we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; set_rd(5'd5, 5'd5, 5'd4); push_exp();
    tick(); set_rd(5'd5, 5'd5, 5'd5); push_exp();

    // Zero register handling.
    tick(); we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1234; set_rd(5'd0, 5'd0, 5'd5); push_exp();
    tick(); set_rd(5'd0, 5'd5, 5'd0); push_exp();
    tick(); busy_set = 1'b1; busy_addr = 5'd0; push_exp();
    tick(); push_exp();

    // Dual-port write collision.
    tick(); we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
            we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22; set_rd(5'd7, 5'd6, 5'd0); push_exp();
    tick(); set_rd(5'd7, 5'd7, 5'd7); push_exp();
    tick(); push_exp();

    // Scoreboard sequence.
    tick(); busy_set = 1'b1; busy_addr = 5'd3; set_rd(5'd3, 5'd9, 5'd0); push_exp();
    tick(); busy_set = 1'b1; busy_addr = 5'd9; set_rd(5'd3, 5'd9, 5'd0); push_exp();
    tick(); set_rd(5'd3, 5'd9, 5'd0); push_exp();
    tick(); we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h33; push_exp();
    tick(); busy_set = 1'b1; busy_addr = 5'd9; we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
            set_rd(5'd9, 5'd3, 5'd9); push_exp();
    tick(); push_exp();

    // Asynchronous reset between edges, with a write in flight.
    tick(); busy_set = 1'b1; busy_addr = 5'd12; we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hCAFE0004;
            push_exp();
    tick(); set_rd(5'd4, 5'd9, 5'd12); push_exp();
    tick(); we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h5555AAAA; set_rd(5'd4, 5'd9, 5'd12);
    #1; rst_n = 1'b0; model_reset(); push_exp();
    tick(); set_rd(5'd4, 5'd9, 5'd12); push_exp();
    tick(); rst_n = 1'b1; set_rd(5'd4, 5'd9, 5'd12); push_exp();

    // Randomized traffic over a narrow address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      tick();
      we0       = 1'($urandom_range(0, 1));
      we1       = 1'($urandom_range(0, 1));
      busy_set  = 1'($urandom_range(0, 1));
      waddr0    = 5'($urandom_range(0, 7));
      waddr1    = 5'($urandom_range(0, 7));
      busy_addr = 5'($urandom_range(0, 7));
      wdata0    = $urandom;
      wdata1    = $urandom;
      set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom % NREGS));
      push_exp();
    end

    tick();
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
